// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter: operation in, result out.
// The shifter sits on the slave modport; the producer/consumer side uses master.
interface pipelined_barrel_shifter_if #(
  parameter int N = 8
);
  localparam int S = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [S-1:0] amt;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;

  modport slave (
    input  in_valid, x, amt, mode, out_ready,
    output in_ready, out_valid, z
  );

  modport master (
    output in_valid, x, amt, mode, out_ready,
    input  in_ready, out_valid, z
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: stage k conditionally shifts by 2^k, so the
// result emerges log2(N) cycles after accept, with one op per cycle.
module pipelined_barrel_shifter #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int S = $clog2(N);

  // Applies one fixed-distance step of the selected shift mode; sign_i is the
  // original operand MSB, so arithmetic fill stays correct across stages.
  function automatic logic [N-1:0] stage_shift(
    input logic [N-1:0] din_i,
    input logic [1:0]   mode_i,
    input logic         sign_i,
    input int unsigned  dist_i
  );
    logic [N-1:0] fill_s;
    logic [N-1:0] res_s;
    fill_s = sign_i ? ~({N{1'b1}} >> dist_i) : {N{1'b0}};
    case (mode_i)
      2'b00:   res_s = din_i >> dist_i;
      2'b01:   res_s = (din_i >> dist_i) | fill_s;
      2'b10:   res_s = din_i << dist_i;
      2'b11:   res_s = (din_i >> dist_i) | (din_i << (N - dist_i));
      default: res_s = din_i;
    endcase
    return res_s;
  endfunction

  logic [N-1:0] data_q [S];
  logic [N-1:0] data_d [S];
  logic [S-1:0] amt_q  [S];
  logic [S-1:0] amt_d  [S];
  logic [1:0]   mode_q [S];
  logic [1:0]   mode_d [S];
  logic [S-1:0] sign_q;
  logic [S-1:0] sign_d;
  logic [S-1:0] valid_q;
  logic [S-1:0] valid_d;

  logic [N-1:0] src_data_s [S];
  logic [S-1:0] src_amt_s  [S];
  logic [1:0]   src_mode_s [S];
  logic [S-1:0] src_sign_s;
  logic [S-1:0] src_valid_s;
  logic         advance_s;

  // Next-state for every stage: load from the predecessor on advance, else hold (bubbles included).
  always_comb begin
    advance_s      = ~valid_q[S-1] | bus.out_ready;
    src_data_s[0]  = bus.x;
    src_amt_s[0]   = bus.amt;
    src_mode_s[0]  = bus.mode;
    src_sign_s     = {S{1'b0}};
    src_valid_s    = {S{1'b0}};
    src_sign_s[0]  = bus.x[N-1];
    src_valid_s[0] = bus.in_valid;
    for (int k = 1; k < S; k++) begin
      src_data_s[k]  = data_q[k-1];
      src_amt_s[k]   = amt_q[k-1];
      src_mode_s[k]  = mode_q[k-1];
      src_sign_s[k]  = sign_q[k-1];
      src_valid_s[k] = valid_q[k-1];
    end
    sign_d  = sign_q;
    valid_d = valid_q;
    for (int k = 0; k < S; k++) begin
      if (advance_s) begin
        if (src_amt_s[k][k]) begin
          data_d[k] = stage_shift(src_data_s[k], src_mode_s[k], src_sign_s[k], 32'd1 << k);
        end else begin
          data_d[k] = src_data_s[k];
        end
        amt_d[k]   = src_amt_s[k];
        mode_d[k]  = src_mode_s[k];
        sign_d[k]  = src_sign_s[k];
        valid_d[k] = src_valid_s[k];
      end else begin
        data_d[k]  = data_q[k];
        amt_d[k]   = amt_q[k];
        mode_d[k]  = mode_q[k];
        sign_d[k]  = sign_q[k];
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Stage registers; reset discards every in-flight operation at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        data_q[k] <= {N{1'b0}};
        amt_q[k]  <= {S{1'b0}};
        mode_q[k] <= 2'b00;
      end
      sign_q  <= {S{1'b0}};
      valid_q <= {S{1'b0}};
    end else begin
      for (int k = 0; k < S; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        mode_q[k] <= mode_d[k];
      end
      sign_q  <= sign_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_q[S-1];
  assign bus.z         = data_q[S-1];
endmodule
